// File: rtl/sblk_pkg.sv
// Shared types and default widths for the superblock row dispatcher.
package sblk_pkg;

    localparam int unsigned DEF_N_ROW    = 10;
    localparam int unsigned DEF_WID_ACT  = 16;
    localparam int unsigned DEF_WID_INST = 14;
    localparam int unsigned DEF_WID_LEN  = 12;
    localparam int unsigned DEF_WID_CNT  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } sblk_state_e;

    typedef enum logic {
        MODE_BCAST   = 1'b0,
        MODE_SCATTER = 1'b1
    } sblk_mode_e;

endpackage

// File: rtl/sblk_rr_sel.sv
// Round-robin helper: returns the next set mask bit above ptr_i, wrapping
// to the lowest set bit. A lone set bit maps onto itself; an empty mask
// leaves the pointer unchanged.
module sblk_rr_sel #(
    parameter int unsigned N_ROW = 10,
    parameter int unsigned PW    = 4
) (
    input  logic [N_ROW-1:0] mask_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [PW-1:0]    ptr_nxt_o
);

    logic          above_found;
    logic          any_found;
    logic [PW-1:0] above_idx;
    logic [PW-1:0] low_idx;

    // Scan high-to-low so the last hit in each class is the lowest index.
    always_comb begin
        above_found = 1'b0;
        any_found   = 1'b0;
        above_idx   = '0;
        low_idx     = '0;
        for (int j = N_ROW - 1; j >= 0; j--) begin
            if (mask_i[j]) begin
                any_found = 1'b1;
                low_idx   = PW'(j);
                if (PW'(j) > ptr_i) begin
                    above_found = 1'b1;
                    above_idx   = PW'(j);
                end
            end
        end
        if (above_found) begin
            ptr_nxt_o = above_idx;
        end else if (any_found) begin
            ptr_nxt_o = low_idx;
        end else begin
            ptr_nxt_o = ptr_i;
        end
    end

endmodule

// File: rtl/sblk_row_disp.sv
// Superblock row dispatcher: accepts one instruction at a time, issues it to
// the masked rows once they are idle, streams activation words to them
// (broadcast or round-robin scatter), then waits for the rows to finish.
//
// state  | meaning
// IDLE   | ready for an instruction; an empty mask is rejected with err
// ISSUE  | waiting for masked rows idle, then one-cycle inst_en_out strobe
// STREAM | moving len activation words to the masked rows
// WAIT   | first cycle ignores status (row busy latency), then rows idle
// DONE   | one-cycle done pulse, completed-instruction count bumped
module sblk_row_disp
    import sblk_pkg::*;
#(
    parameter int unsigned N_ROW    = DEF_N_ROW,
    parameter int unsigned WID_ACT  = DEF_WID_ACT,
    parameter int unsigned WID_INST = DEF_WID_INST,
    parameter int unsigned WID_LEN  = DEF_WID_LEN,
    parameter int unsigned WID_CNT  = DEF_WID_CNT
) (
    input  logic                        clk_l,
    input  logic                        rst_n,
    input  logic [WID_INST-1:0]         s_inst_data,
    input  logic [N_ROW-1:0]            s_inst_mask,
    input  logic                        s_inst_mode,
    input  logic [WID_LEN-1:0]          s_inst_len,
    input  logic                        s_inst_vld,
    output logic                        s_inst_rdy,
    input  logic [2*WID_ACT-1:0]        s_act_data,
    input  logic                        s_act_vld,
    output logic                        s_act_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]  act_data_out,
    output logic [N_ROW-1:0]            act_data_out_vld,
    input  logic [N_ROW-1:0]            act_data_in_req,
    output logic [WID_INST*N_ROW-1:0]   inst_data_out,
    output logic [N_ROW-1:0]            inst_en_out,
    input  logic [N_ROW-1:0]            status_sblk,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [WID_CNT-1:0]          inst_cnt
);

    localparam int unsigned AW = 2 * WID_ACT;
    localparam int unsigned PW = (N_ROW > 1) ? $clog2(N_ROW) : 1;

    sblk_state_e                 state_q, state_d;
    logic [N_ROW-1:0]            mask_q;
    sblk_mode_e                  mode_q;
    logic [WID_LEN-1:0]          len_q;
    logic [WID_INST-1:0]         data_q;
    logic [PW-1:0]               ptr_q;
    logic [WID_LEN-1:0]          cnt_q;
    logic                        wait_first_q;
    logic [N_ROW-1:0]            inst_en_q;
    logic [WID_INST*N_ROW-1:0]   inst_data_q;
    logic [N_ROW-1:0]            act_vld_q;
    logic [AW*N_ROW-1:0]         act_data_q;
    logic                        err_q;
    logic [WID_CNT-1:0]          inst_cnt_q;

    logic          inst_hs;
    logic          accept;
    logic          rows_idle;
    logic          bcast_ok;
    logic          word_ok;
    logic          act_fire;
    logic          last_word;
    logic [PW-1:0] ptr_first;
    logic [PW-1:0] ptr_next;

    assign inst_hs   = s_inst_vld & s_inst_rdy;
    assign accept    = inst_hs & (|s_inst_mask);
    assign rows_idle = ~|(status_sblk & mask_q);
    assign bcast_ok  = &(act_data_in_req | ~mask_q);
    assign word_ok   = (mode_q == MODE_SCATTER) ? act_data_in_req[ptr_q] : bcast_ok;
    assign act_fire  = s_act_vld & s_act_rdy;
    assign last_word = (cnt_q == (len_q - WID_LEN'(1)));

    // Starting from the top row, the "next" set bit is the lowest one.
    sblk_rr_sel #(.N_ROW(N_ROW), .PW(PW)) u_rr_first (
        .mask_i    (s_inst_mask),
        .ptr_i     (PW'(N_ROW - 1)),
        .ptr_nxt_o (ptr_first)
    );

    sblk_rr_sel #(.N_ROW(N_ROW), .PW(PW)) u_rr_next (
        .mask_i    (mask_q),
        .ptr_i     (ptr_q),
        .ptr_nxt_o (ptr_next)
    );

    // State register.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (rows_idle) state_d = STREAM;
            STREAM:  if (len_q == '0 || (act_fire && last_word)) state_d = WAIT;
            WAIT:    if (!wait_first_q && rows_idle) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs; s_inst_rdy is held low while in reset.
    always_comb begin
        s_inst_rdy = (state_q == IDLE) & rst_n;
        s_act_rdy  = (state_q == STREAM) & (len_q != '0) & word_ok;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
    end

    // Latch the accepted instruction; track words sent and the scatter pointer.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            mode_q <= MODE_BCAST;
            len_q  <= '0;
            data_q <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            mask_q <= s_inst_mask;
            mode_q <= sblk_mode_e'(s_inst_mode);
            len_q  <= s_inst_len;
            data_q <= s_inst_data;
            ptr_q  <= ptr_first;
            cnt_q  <= '0;
        end else if (act_fire) begin
            cnt_q <= cnt_q + WID_LEN'(1);
            if (mode_q == MODE_SCATTER) begin
                ptr_q <= ptr_next;
            end
        end
    end

    // Instruction strobe to the masked rows as the ISSUE wait clears.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            inst_en_q   <= '0;
            inst_data_q <= '0;
        end else begin
            inst_en_q <= '0;
            if (state_q == ISSUE && rows_idle) begin
                inst_en_q <= mask_q;
                for (int r = 0; r < N_ROW; r++) begin
                    if (mask_q[r]) begin
                        inst_data_q[r*WID_INST +: WID_INST] <= data_q;
                    end
                end
            end
        end
    end

    // One registered valid pulse per fired activation word.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            act_vld_q  <= '0;
            act_data_q <= '0;
        end else begin
            act_vld_q <= '0;
            if (act_fire) begin
                for (int r = 0; r < N_ROW; r++) begin
                    if ((mode_q == MODE_BCAST) ? mask_q[r] : (ptr_q == PW'(r))) begin
                        act_vld_q[r]            <= 1'b1;
                        act_data_q[r*AW +: AW] <= s_act_data;
                    end
                end
            end
        end
    end

    // Reject pulse, WAIT first-cycle flag and the completion counter.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            err_q        <= 1'b0;
            wait_first_q <= 1'b0;
            inst_cnt_q   <= '0;
        end else begin
            err_q        <= inst_hs & ~(|s_inst_mask);
            wait_first_q <= (state_q == STREAM) && (state_d == WAIT);
            if (state_q == WAIT && state_d == DONE) begin
                inst_cnt_q <= inst_cnt_q + WID_CNT'(1);
            end
        end
    end

    assign inst_en_out      = inst_en_q;
    assign inst_data_out    = inst_data_q;
    assign act_data_out_vld = act_vld_q;
    assign act_data_out     = act_data_q;
    assign err              = err_q;
    assign inst_cnt         = inst_cnt_q;

endmodule

// File: doc/sblk_row_disp.md
SBLK_ROW_DISP -- requirements
Module: sblk_row_disp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_ROW, 10, number of superblock rows served.
- WID_ACT, 16, activation element width; row word is 2*WID_ACT.
- WID_INST, 14, instruction word width.
- WID_LEN, 12, activation word-count field width.
- WID_CNT, 16, completed-instruction counter width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_l, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- s_inst_data, in, WID_INST, instruction payload.
- s_inst_mask, in, N_ROW, target-row mask.
- s_inst_mode, in, 1, 0 = broadcast activations, 1 = scatter activations.
- s_inst_len, in, WID_LEN, activation words for this instruction.
- s_inst_vld / s_inst_rdy, in / out, 1 each, instruction handshake.
- s_act_data, in, 2*WID_ACT, activation word.
- s_act_vld / s_act_rdy, in / out, 1 each, activation handshake.
- act_data_out, out, 2*WID_ACT*N_ROW, per-row activation; row r at slice [r*2*WID_ACT +: 2*WID_ACT].
- act_data_out_vld, out, N_ROW, per-row activation valid.
- act_data_in_req, in, N_ROW, per-row "can accept" flag from the rows.
- inst_data_out, out, WID_INST*N_ROW, per-row instruction.
- inst_en_out, out, N_ROW, per-row instruction strobe.
- status_sblk, in, N_ROW, per-row busy flag (1 = busy).
- busy, out, 1, FSM not in IDLE.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle pulse on a rejected instruction.
- inst_cnt, out, WID_CNT, count of completed instructions.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, STREAM, WAIT and DONE.
REQ-004 IDLE: s_inst_rdy=1. On handshake, mask/mode/len/data SHALL be latched and the FSM SHALL go to ISSUE.
REQ-005 A handshake with s_inst_mask==0 SHALL be dropped, err SHALL pulse the next cycle, and the FSM SHALL stay in IDLE.
REQ-006 ISSUE SHALL hold until every masked row has status_sblk=0. It SHALL then, for exactly one cycle, drive inst_en_out=mask (registered) and copy the latched data into every masked row slice of inst_data_out, then go to STREAM.
REQ-007 STREAM with latched len==0 SHALL go directly to WAIT; otherwise it SHALL count delivered words and go to WAIT in the cycle the len-th word fires.
REQ-008 Broadcast fire condition: s_act_vld & all masked act_data_in_req. s_act_rdy SHALL equal that condition while in STREAM and 0 in every other state.
REQ-009 Broadcast fire effect: next cycle, act_data_out_vld=mask and every masked slice holds the word.
REQ-010 Scatter: a round-robin pointer SHALL start at the lowest set mask bit. Fire condition: s_act_vld & act_data_in_req[ptr]. Fire effect: next cycle only vld[ptr] is set.
REQ-011 After each scatter fire, ptr SHALL advance to the next set mask bit and wrap to the lowest. With a single-bit mask, ptr SHALL stay fixed.
REQ-012 act_data_out_vld SHALL be a one-cycle registered pulse per fire, with no back-to-back stall penalty (one word per cycle maximum). Unmasked rows SHALL never see vld or inst_en.
REQ-013 WAIT SHALL ignore status_sblk in its first cycle (row busy-assertion latency of one cycle). It SHALL then hold until all masked status_sblk=0 and go to DONE.
REQ-014 DONE SHALL last one cycle: done=1, inst_cnt increments (wrapping at 2^WID_CNT), then IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Latency from the instruction handshake (idle rows) to inst_en_out SHALL be 2 cycles; from an act fire to act_data_out_vld SHALL be 1 cycle.

Reset
REQ-017 rst_n low SHALL asynchronously force the FSM to IDLE and clear, at any point including mid-STREAM:
- all outputs to 0;
- counters, ptr and latched fields to 0.
REQ-018 The first cycle after deassertion SHALL behave as IDLE with s_inst_rdy=1.

Structure
REQ-019 A shared package sblk_pkg SHALL hold the FSM state enum, the mode enum (MODE_BCAST, MODE_SCATTER) and a default-width localparam set.
REQ-020 The next-set-bit-with-wrap logic SHALL be a sub-module sblk_rr_sel (inputs: mask, current ptr; output: next ptr).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Broadcast, N_ROW=10, mask=0x3FF, len=4, all req=1 -> 4 fires in 4 cycles; each fire sets vld=0x3FF; one done pulse; inst_cnt=1.
- Scatter, mask=0b1010010000, len=5 -> vld order row4, row7, row9, row4, row7.
- Row 2 status_sblk=1 for 20 cycles, mask includes row 2 -> inst_en_out held off until release, then a single pulse.
- mask=0 -> err pulse, s_act_rdy stays 0, FSM stays IDLE.
- len=0, mask=0x001 -> no act_vld, done only after row 0 busy drops.
- rst_n low on the 3rd act fire of len=8 -> all outputs 0 immediately; next instruction completes normally; inst_cnt restarts from 0.
